// File: rtl/twos_comp_seq.sv
// twos_comp_seq: chunk-serial pass / one's complement / negate / absolute value with valid-ready handshake
module twos_comp_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] R,
  output logic             ovf,
  output logic             zero
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, r_q, r_d;
  logic [1:0]       mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             inv_q, inv_d, carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [CHUNK-1:0] chunk;
  logic [CHUNK:0]   sum;
  logic             last, a_neg;
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign R         = r_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign a_neg     = A[WIDTH-1];
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    carry_d = carry_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    chunk   = a_q[int'(cnt_q)*CHUNK +: CHUNK];
    sum     = {1'b0, inv_q ? ~chunk : chunk} + (CHUNK+1)'(carry_q);
    last    = (cnt_q == CW'(N - 1));
    if (state_q == IDLE && in_valid) begin
      state_d = BUSY;
      a_d     = A;
      mode_d  = mode;
      cnt_d   = '0;
      inv_d   = (mode == 2'b01) || (mode == 2'b10) || (mode == 2'b11 && a_neg);
      carry_d = (mode == 2'b10) || (mode == 2'b11 && a_neg);
    end else if (state_q == BUSY) begin
      r_d[int'(cnt_q)*CHUNK +: CHUNK] = sum[CHUNK-1:0];
      carry_d = sum[CHUNK];
      cnt_d   = last ? cnt_q : cnt_q + CW'(1);
      state_d = last ? DONE : BUSY;
      // flags only matter once the last chunk lands, so settle them then
      zero_d  = last ? (r_d == '0) : zero_q;
      ovf_d   = last ? (mode_q[1] && a_q == {1'b1, {(WIDTH-1){1'b0}}}) : ovf_q;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      mode_q  <= '0;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
      carry_q <= 1'b0;
      r_q     <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
      carry_q <= carry_d;
      r_q     <= r_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end
endmodule

// File: tb/tb_twos_comp_seq.sv
// tb_twos_comp_seq: directed + random checks of twos_comp_seq at CHUNK 8, 32 and 4
module tb_twos_comp_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] av = '0;
  logic [1:0]  mv = '0;
  logic        iv [3];
  logic        ordy [3];
  logic        irdy [3];
  logic        ov [3];
  logic [31:0] r_o [3];
  logic        ovf_o [3];
  logic        zero_o [3];
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  twos_comp_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .A(av), .mode(mv),
    .out_valid(ov[0]), .out_ready(ordy[0]), .R(r_o[0]), .ovf(ovf_o[0]), .zero(zero_o[0]));
  twos_comp_seq #(.WIDTH(32), .CHUNK(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .A(av), .mode(mv),
    .out_valid(ov[1]), .out_ready(ordy[1]), .R(r_o[1]), .ovf(ovf_o[1]), .zero(zero_o[1]));
  twos_comp_seq #(.WIDTH(32), .CHUNK(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]), .A(av), .mode(mv),
    .out_valid(ov[2]), .out_ready(ordy[2]), .R(r_o[2]), .ovf(ovf_o[2]), .zero(zero_o[2]));
  function automatic int lat_of(input int d);
    return (d == 0) ? 4 : (d == 1) ? 1 : 8;
  endfunction
  function automatic logic [31:0] ref_r(input logic [31:0] a, input logic [1:0] m);
    case (m)
      2'd0: return a;
      2'd1: return ~a;
      2'd2: return 32'd0 - a;
      default: return $signed(a) < 0 ? 32'd0 - a : a;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input int d, input logic [31:0] a, input logic [1:0] m,
                        input string tag, input int hold);
    int lat;
    logic [31:0] er;
    er = ref_r(a, m);
    @(negedge clk);
    chk({tag, " ready"}, 32'(irdy[d]), 32'd1);
    av = a;
    mv = m;
    iv[d] = 1'b1;
    @(posedge clk);
    #1 iv[d] = 1'b0;
    chk({tag, " busy"}, 32'(irdy[d]), 32'd0);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (ov[d]) break;
    end
    chk({tag, " latency"}, 32'(lat), 32'(lat_of(d)));
    chk({tag, " R"}, r_o[d], er);
    chk({tag, " ovf"}, 32'(ovf_o[d]), 32'(m[1] && a == 32'h8000_0000));
    chk({tag, " zero"}, 32'(zero_o[d]), 32'(er == 32'd0));
    if (hold > 0) begin
      @(negedge clk);
      av = ~a;
      iv[d] = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        chk({tag, " hold R"}, r_o[d], er);
        chk({tag, " hold ovf"}, 32'(ovf_o[d]), 32'(m[1] && a == 32'h8000_0000));
        chk({tag, " hold zero"}, 32'(zero_o[d]), 32'(er == 32'd0));
        chk({tag, " hold valid"}, 32'(ov[d]), 32'd1);
        chk({tag, " hold ready"}, 32'(irdy[d]), 32'd0);
      end
    end
    @(negedge clk);
    ordy[d] = 1'b1;
    @(posedge clk);
    #1 ordy[d] = 1'b0;
    iv[d] = 1'b0;
    chk({tag, " released"}, 32'(ov[d]), 32'd0);
    chk({tag, " idle"}, 32'(irdy[d]), 32'd1);
  endtask
  initial begin
    logic [31:0] a;
    logic [1:0]  m;
    int          d;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0;
      ordy[i] = 1'b0;
    end
    #3;
    chk("reset R", r_o[0], 32'd0);
    chk("reset valid", 32'(ov[0]), 32'd0);
    chk("reset ready", 32'(irdy[0]), 32'd0);
    chk("reset ovf", 32'(ovf_o[0]), 32'd0);
    chk("reset zero", 32'(zero_o[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_op(0, 32'h0000_0001, 2'd2, "neg1", 0);
    run_op(0, 32'h8000_0000, 2'd2, "negmin", 0);
    run_op(0, 32'hFFFF_FFF6, 2'd3, "abs-10", 0);
    run_op(0, 32'h0000_000A, 2'd3, "abs10", 0);
    run_op(0, 32'h8000_0000, 2'd3, "absmin", 0);
    run_op(0, 32'h0000_0000, 2'd2, "neg0", 0);
    run_op(0, 32'h0000_FFFF, 2'd1, "inv", 0);
    run_op(0, 32'h1234_5678, 2'd0, "pass", 0);
    run_op(0, 32'hDEAD_BEEF, 2'd2, "hold", 5);
    @(negedge clk);
    av = 32'h0000_0005;
    mv = 2'd2;
    iv[0] = 1'b1;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst valid", 32'(ov[0]), 32'd0);
    chk("rst R", r_o[0], 32'd0);
    chk("rst ready", 32'(irdy[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post-rst ready", 32'(irdy[0]), 32'd1);
    repeat (6) @(posedge clk);
    #1 chk("post-rst no result", 32'(ov[0]), 32'd0);
    run_op(0, 32'h0000_0005, 2'd2, "post-rst neg5", 0);
    run_op(1, 32'h0000_0002, 2'd2, "c32 neg2", 0);
    run_op(1, 32'h8000_0000, 2'd3, "c32 absmin", 0);
    run_op(2, 32'h0000_0000, 2'd2, "c4 neg0", 0);
    run_op(2, 32'hF000_0001, 2'd3, "c4 abs", 0);
    for (int i = 0; i < 40; i++) begin
      d = int'($urandom_range(0, 2));
      m = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: a = 32'h8000_0000;
        1: a = 32'h0000_0000;
        2: a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      run_op(d, a, m, "rand", (i % 8 == 7) ? 2 : 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
